// File: rtl/rnd_arb_pkg.sv
// ---------------------------------------------------------------------------
// rnd_arb_pkg
// Shared types and helpers for the random-generator share arbiter.
//   rnd_state_e : arbiter FSM state encoding (also exported for debug)
//   DEF_N_REQ   : default number of requesters
//   DEF_DATA_W  : default generator data width
//   mod_inc()   : increment modulo n, used to advance the round-robin pointer
// ---------------------------------------------------------------------------
package rnd_arb_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } rnd_state_e;

    // (v + 1) mod n without a divider; v is always < n here.
    function automatic int mod_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority picker. Scans indices ptr, ptr+1, ...
// wrapping modulo N_REQ; the first asserted request wins.
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  PTR_W  index holding highest priority
//   winner out N_REQ  one-hot winner (all zero when no request)
//   valid  out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rnd_share_arbiter.sv
// ---------------------------------------------------------------------------
// rnd_share_arbiter
// Shares one random-round generator among N_REQ requesters. A requester
// holds req; the arbiter picks a winner round-robin, pulses rnd_start,
// waits for rnd_done, captures rnd_data and returns a one-cycle done with
// the data to the winner.
//
// Handshake: req is a level held until the requester sees its own done
// pulse and is sampled only in IDLE; gnt is one-hot and held from GRANT
// through RESP; done is a single-cycle pulse in RESP; rnd_start is a
// single-cycle pulse; rnd_done/rnd_data are sampled only in WAIT, so
// rnd_done at any other time is ignored.
//
// Optional feature (macro RND_TIMEOUT_EN): WAIT watchdog. After TIMEOUT_CYC
// WAIT cycles without rnd_done the transaction finishes with rsp_data=0 and
// err pulsed alongside done. Without the macro err is constant 0.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset
//   req        in   N_REQ   per-requester request level
//   gnt        out  N_REQ   one-hot grant
//   done       out  N_REQ   one-cycle completion pulse to the winner
//   rsp_data   out  DATA_W  captured generator value, held until next capture
//   rnd_start  out  1       one-cycle generator start pulse
//   rnd_done   in   1       generator completion
//   rnd_data   in   DATA_W  generator result, valid with rnd_done
//   busy       out  1       high in any state other than IDLE
//   err        out  1       one-cycle timeout pulse in RESP
//   dbg_state  out  3       current FSM state (debug)
//   dbg_ptr    out  PTR_W   round-robin priority pointer (debug)
// ---------------------------------------------------------------------------
module rnd_share_arbiter
    import rnd_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 64,
    localparam int PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  done,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rnd_start,
    input  logic              rnd_done,
    input  logic [DATA_W-1:0] rnd_data,
    output logic              busy,
    output logic              err,
    output rnd_state_e        dbg_state,
    output logic [PTR_W-1:0]  dbg_ptr
);

    rnd_state_e       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;

    logic [N_REQ-1:0] pick_oh;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;

`ifdef RND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    // Winner index, kept so the pointer can advance past it in RESP.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            gnt       <= '0;
            done      <= '0;
            rnd_start <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= '0;
`ifdef RND_TIMEOUT_EN
            err       <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            // Pulse outputs default low; set only for the one cycle they apply.
            done      <= '0;
            rnd_start <= 1'b0;
`ifdef RND_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt     <= pick_oh;
                        win_idx <= pick_idx;
                        busy    <= 1'b1;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // One settle cycle for the requester's mux before start.
                    rnd_start <= 1'b1;
                    state     <= ST_START;
                end
                ST_START: begin
`ifdef RND_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rnd_done) begin
                        // A real completion wins even on the terminal cycle.
                        rsp_data <= rnd_data;
                        done     <= gnt;
                        state    <= ST_RESP;
                    end
`ifdef RND_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data <= '0;
                        done     <= gnt;
                        err      <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= PTR_W'(mod_inc(int'(win_idx), N_REQ));
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef RND_TIMEOUT_EN
    assign err = 1'b0;
`endif

    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_rnd_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rnd_share_arbiter
// Directed bench for rnd_share_arbiter with hand-computed expectations.
// Timeout scenarios are compiled in only when RND_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_rnd_share_arbiter;
    import rnd_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic [W-1:0] rsp_data;
    logic         rnd_start;
    logic         rnd_done;
    logic [W-1:0] rnd_data;
    logic         busy;
    logic         err;
    rnd_state_e   dbg_state;
    logic [1:0]   dbg_ptr;

    always #5 clk = ~clk;

    rnd_share_arbiter #(
        .N_REQ       (N),
        .DATA_W      (W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .done      (done),
        .rsp_data  (rsp_data),
        .rnd_start (rnd_start),
        .rnd_done  (rnd_done),
        .rnd_data  (rnd_data),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- scoreboard counters / monitors ----------------
    int n_tests   = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int oh_err    = 0;

    always @(posedge clk) begin
        if (!rst && rnd_start) start_cnt++;
        if ($countones(gnt) > 1 || $countones(done) > 1) oh_err++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Called at an IDLE sample point with req already driven. d is the WAIT
    // cycle (1 = first) in which rnd_done is raised; spur raises rnd_done
    // during START as well.
    task automatic run_txn(input string tag, input logic [N-1:0] exp_gnt, input int d,
                           input logic [W-1:0] data, input bit spur, input logic [1:0] exp_ptr);
        int  s0;
        bit  seen;
        seen = 1'b0;
        s0   = start_cnt;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (gnt != '0) seen = 1'b1;
        end
        check({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
        tick();
        check({tag, "_start"}, 64'(rnd_start), 64'd1);
        if (spur) rnd_done = 1'b1;
        tick();
        rnd_done = 1'b0;
        for (int k = 1; k < d; k++) tick();
        check({tag, "_early"}, 64'(dbg_state), 64'(ST_WAIT));
        rnd_done = 1'b1;
        rnd_data = data;
        tick();
        rnd_done = 1'b0;
        check({tag, "_done"}, 64'(done), 64'(exp_gnt));
        check({tag, "_data"}, 64'(rsp_data), 64'(data));
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_nstart"}, 64'(start_cnt - s0), 64'd1);
        tick();
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_ptr"}, 64'(dbg_ptr), 64'(exp_ptr));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        logic [N-1:0] order [8];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst      = 1'b1;
        req      = '0;
        rnd_done = 1'b0;
        rnd_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_gnt",   64'(gnt), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_start", 64'(rnd_start), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_data",  64'(rsp_data), 64'd0);
        check("rst_ptr",   64'(dbg_ptr), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // All requesters constant: strict 0,1,2,3,0,1,2,3 rotation.
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("all%0d", i), order[i], (i % 3) + 1, 32'h1000_0000 + i, 1'b0,
                    2'((i + 1) % 4));
        end
        req = '0;
        tick();

        // Single requester with exact cycle latencies.
        req = 4'b0010;
        tick();
        check("single_gnt_t1",   64'(gnt), 64'b0010);
        check("single_start_t1", 64'(rnd_start), 64'd0);
        tick();
        check("single_start_t2", 64'(rnd_start), 64'd1);
        tick();
        check("single_done_t3",  64'(done), 64'd0);
        rnd_done = 1'b1;
        rnd_data = 32'hDEADBEEF;
        tick();
        rnd_done = 1'b0;
        req      = '0;
        check("single_done_t4",  64'(done), 64'b0010);
        check("single_data_t4",  64'(rsp_data), 64'hDEADBEEF);
        check("single_busy_t4",  64'(busy), 64'd1);
        tick();
        check("single_busy_t5",  64'(busy), 64'd0);
        check("single_done_t5",  64'(done), 64'd0);
        check("single_gnt_t5",   64'(gnt), 64'd0);
        check("single_ptr",      64'(dbg_ptr), 64'd2);

        // Wrap: serve 2 (ptr -> 3), then req=1001 grants 3 then 0.
        req = 4'b0100;
        run_txn("serve2", 4'b0100, 1, 32'h2222_2222, 1'b0, 2'd3);
        req = 4'b1001;
        run_txn("wrap3", 4'b1000, 2, 32'h3333_3333, 1'b0, 2'd0);
        run_txn("wrap0", 4'b0001, 1, 32'h0000_0A0A, 1'b0, 2'd1);
        req = '0;
        tick();

        // Spurious rnd_done in IDLE must not start anything.
        s0 = start_cnt;
        rnd_done = 1'b1;
        tick();
        rnd_done = 1'b0;
        check("spur_idle_busy",  64'(busy), 64'd0);
        check("spur_idle_state", 64'(dbg_state), 64'(ST_IDLE));
        check("spur_idle_start", 64'(start_cnt - s0), 64'd0);

        // 20-cycle generator delay with a spurious pulse in START.
        req = 4'b0001;
        run_txn("slow", 4'b0001, 20, 32'h5A5A_A5A5, 1'b1, 2'd1);
        req = '0;
        tick();

        // Reset in WAIT aborts; pointer returns to 0.
        req = 4'b0010;
        tick();
        tick();
        tick();
        check("rstw_state", 64'(dbg_state), 64'(ST_WAIT));
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        check("rstw_gnt",   64'(gnt), 64'd0);
        check("rstw_busy",  64'(busy), 64'd0);
        check("rstw_ptr",   64'(dbg_ptr), 64'd0);
        check("rstw_state", 64'(dbg_state), 64'(ST_IDLE));
        req = 4'b0100;
        run_txn("after_rst", 4'b0100, 1, 32'h0BAD_F00D, 1'b0, 2'd3);
        req = '0;
        tick();

`ifdef RND_TIMEOUT_EN
        // Watchdog fires after TO WAIT cycles with no rnd_done.
        req = 4'b0010;
        tick();
        check("to_gnt", 64'(gnt), 64'b0010);
        tick();
        check("to_start", 64'(rnd_start), 64'd1);
        repeat (TO) tick();
        check("to_w8_state", 64'(dbg_state), 64'(ST_WAIT));
        check("to_w8_done",  64'(done), 64'd0);
        tick();
        req = '0;
        check("to_done", 64'(done), 64'b0010);
        check("to_err",  64'(err), 64'd1);
        check("to_data", 64'(rsp_data), 64'd0);
        tick();
        check("to_err_clr", 64'(err), 64'd0);
        check("to_ptr",     64'(dbg_ptr), 64'd2);

        // rnd_done in the terminal WAIT cycle takes precedence.
        req = 4'b1000;
        tick();
        check("tol_gnt", 64'(gnt), 64'b1000);
        tick();
        repeat (TO) tick();
        rnd_done = 1'b1;
        rnd_data = 32'hCAFE_F00D;
        tick();
        rnd_done = 1'b0;
        req      = '0;
        check("tol_done", 64'(done), 64'b1000);
        check("tol_err",  64'(err), 64'd0);
        check("tol_data", 64'(rsp_data), 64'hCAFE_F00D);
        tick();
`endif

        check("onehot", 64'(oh_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rnd_share_arbiter.md
Name: rnd_share_arbiter

Overview:
- Shares the single random-round generator (Start_rnd/Done_rnd handshake) among N_REQ requester controllers.
- Each requester holds a request. The arbiter picks one requester round-robin, pulses the generator start, waits for the generator's done, captures its data, and returns a one-cycle done plus the data to the winner.
- Sits between the per-datapath sequencers and the shared generator.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, generator output width.
- TIMEOUT_CYC, 64, WAIT-state watchdog limit in cycles. Used only with RND_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  per-requester request level. Held high until own done pulse.
- gnt  out  N_REQ  one-hot grant. Held from GRANT through RESP inclusive.
- done  out  N_REQ  one-cycle pulse to the granted requester in RESP.
- rsp_data  out  DATA_W  captured generator value. Valid in RESP, held until next capture.
- rnd_start  out  1  one-cycle start pulse to the generator.
- rnd_done  in  1  generator completion. Sampled only in WAIT.
- rnd_data  in  DATA_W  generator result. Valid with rnd_done.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle timeout pulse in RESP. Tied 0 without RND_TIMEOUT_EN.

Behaviour:
- Reset: state IDLE, priority pointer ptr=0. gnt, done, rnd_start, busy, err = 0. rsp_data = 0. Reset mid-transaction aborts immediately; the generator is not notified.
- FSM states: IDLE, GRANT, START, WAIT, RESP.
  - IDLE: if any req, pick the winner, register gnt one-hot, go to GRANT. Otherwise stay.
  - GRANT: gnt stable, go to START (one settle cycle for the requester's mux).
  - START: rnd_start=1 for this cycle only, go to WAIT.
  - WAIT: on rnd_done=1, capture rnd_data into rsp_data and go to RESP. Otherwise stay.
  - RESP: done[winner]=1, update ptr=(winner+1) mod N_REQ, go to IDLE. gnt drops entering IDLE.
- Latency: req first seen in IDLE at cycle t gives gnt at t+1, rnd_start at t+2, and WAIT from t+3. rnd_done at cycle w gives done/rsp_data at w+1. Minimum request-to-done is 4 cycles (rnd_done in the first WAIT cycle).
- Round-robin selection: scan indices ptr, ptr+1, …, wrapping modulo N_REQ; the first set req wins. Wrap-around from N_REQ-1 to 0 is required.
- req is sampled only in IDLE.
  - A req that falls after grant does not abort; the transaction completes and done is still pulsed.
  - A requester must drop req the cycle after its done pulse; otherwise it becomes re-eligible at lowest priority.
- rnd_done outside WAIT (including the START cycle) is ignored.
- rnd_done and a new req in the same cycle: no interaction. The new req waits for IDLE.
- busy = (state != IDLE).
- At most one bit of gnt and done is ever high.

Optional Feature:
- Macro: RND_TIMEOUT_EN.
- With it: a $clog2(TIMEOUT_CYC+1)-bit counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT_CYC with rnd_done still low, go to RESP with rsp_data=0.
  - In that RESP cycle, err=1 alongside done.
  - rnd_done arriving in that same terminal cycle takes precedence: normal capture, err=0.
- Without it: WAIT is unbounded, no counter is instantiated, err is constant 0.

Decomposition:
- Package rnd_arb_pkg:
  - State enum (IDLE, GRANT, START, WAIT, RESP).
  - Default N_REQ/DATA_W constants.
  - Function for the modulo-N increment.
- Sub-module rr_picker: combinational round-robin priority picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot winner plus a valid bit.
- Everything else is in the top-level FSM.

Test Plan:
- Single requester: req=4'b0010, rnd_done one cycle after START with rnd_data=32'hDEADBEEF.
  - Expect gnt=0010 at t+1, rnd_start at t+2, done=0010 and rsp_data=DEADBEEF at t+4.
  - Expect busy low at t+5.
- All requesters constant, req=1111, 8 transactions.
  - Expect grant order 0,1,2,3,0,1,2,3, each exactly one transaction, no repeats.
- Wrap: ptr=3 after serving 2, then req=1001.
  - Expect grant to 3, then to 0.
- Generator delay 20 cycles with spurious rnd_done pulses in IDLE and START.
  - Spurious pulses are ignored; exactly one rnd_start per transaction; done arrives 1 cycle after the real rnd_done.
- Reset asserted in WAIT.
  - Next cycle: gnt=0, busy=0, ptr=0.
  - A following req=0100 is granted normally.
- RND_TIMEOUT_EN with TIMEOUT_CYC=8 and rnd_done never asserted.
  - After 8 WAIT cycles, done and err pulse together with rsp_data=0.
  - Rerun with rnd_done in the 8th cycle: err=0 and the data is captured.
